dct_mac_array: RTL and testbench

- Parametrised 1-D DCT/IDCT matrix-multiply stage: Y = C·X over a PTS-point column.
- One input sample per accepted beat; each of PTS lanes multiply-accumulates that sample with its own coefficient.
- After PTS beats, emits all PTS lane results in parallel, fixed-point scaled and saturated.
- Sits between the level-shift/row buffer and the transpose memory; two instances form the 2-D DCT.
- Successor to the fixed 8-point stage: adds generic point count and widths, valid/ready handshake, saturation and optional rounding.

---
 rtl/dct_mac_array.sv | 124 ++++++++++++
 tb/tb_dct_mac_array.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_array.sv
// Parametrised 1-D DCT/IDCT multiply-accumulate stage: each of PTS lanes accumulates x[k]*c[i][k]
// over one column, then emits scaled, saturated results. Define DCT_MAC_ROUND_EN for round-half-up output scaling.
module dct_mac_array #(
  parameter int PTS  = 8,
  parameter int XW   = 12,
  parameter int CW   = 8,
  parameter int FRAC = 7,
  parameter int OW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [XW-1:0]     in_x,
  input  logic [PTS*CW-1:0]        in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PTS*OW-1:0]        out_y,
  output logic [PTS-1:0]           out_sat,
  output logic [$clog2(PTS)-1:0]   out_col
);

  localparam int KW = $clog2(PTS);
  localparam int PW = XW + CW;
  localparam int AW = XW + CW + KW;
`ifdef DCT_MAC_ROUND_EN
  // One spare bit so the rounding addend can never wrap the sum.
  localparam int AWI = AW + 1;
  localparam int RND = (FRAC > 0) ? (2 ** FRAC) / 2 : 0;
`else
  localparam int AWI = AW;
  localparam int RND = 0;
`endif
  localparam int SW = (AWI > OW) ? AWI : OW + 1;

  localparam logic signed [SW-1:0] YMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] YMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [KW-1:0]           k_r;
  logic [KW-1:0]           col_r;
  logic [KW-1:0]           out_col_r;
  logic                    out_valid_r;
  logic [PTS*OW-1:0]       out_y_r;
  logic [PTS-1:0]          out_sat_r;
  logic signed [AWI-1:0]   acc_r [PTS];

  logic signed [PW-1:0]    prod_s [PTS];
  logic signed [AWI-1:0]   sum_s  [PTS];
  logic signed [AWI-1:0]   rnd_s  [PTS];
  logic signed [SW-1:0]    shr_s  [PTS];
  logic [OW-1:0]           y_s    [PTS];
  logic [PTS-1:0]          sat_s;
  logic                    last_s;
  logic                    beat_s;

  assign out_valid = out_valid_r;
  assign out_y     = out_y_r;
  assign out_sat   = out_sat_r;
  assign out_col   = out_col_r;

  // Handshake, per-lane MAC sum, output scaling and saturation.
  always_comb begin
    last_s   = (k_r == KW'(PTS-1));
    in_ready = !(last_s && out_valid_r && !out_ready);
    beat_s   = in_valid && in_ready;
    sat_s    = {PTS{1'b0}};
    for (int i = 0; i < PTS; i++) begin
      // Operands sign-extended to the full product width, so the low PW bits are exact.
      prod_s[i] = {{CW{in_x[XW-1]}}, in_x} *
                  {{XW{in_coef[i*CW+CW-1]}}, in_coef[i*CW +: CW]};
      if (k_r == {KW{1'b0}}) begin
        sum_s[i] = AWI'(prod_s[i]);
      end else begin
        sum_s[i] = acc_r[i] + AWI'(prod_s[i]);
      end
      rnd_s[i] = sum_s[i] + AWI'(RND);
      shr_s[i] = SW'(rnd_s[i]) >>> FRAC;
      if (shr_s[i] > YMAX) begin
        y_s[i]   = YMAX[OW-1:0];
        sat_s[i] = 1'b1;
      end else if (shr_s[i] < YMIN) begin
        y_s[i]   = YMIN[OW-1:0];
        sat_s[i] = 1'b1;
      end else begin
        y_s[i]   = shr_s[i][OW-1:0];
        sat_s[i] = 1'b0;
      end
    end
  end

  // Sample counter, accumulators and the held output column.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_r         <= {KW{1'b0}};
      col_r       <= {KW{1'b0}};
      out_col_r   <= {KW{1'b0}};
      out_valid_r <= 1'b0;
      out_y_r     <= {(PTS*OW){1'b0}};
      out_sat_r   <= {PTS{1'b0}};
      for (int i = 0; i < PTS; i++) begin
        acc_r[i] <= {AWI{1'b0}};
      end
    end else begin
      if (beat_s) begin
        k_r <= k_r + KW'(1);
        for (int i = 0; i < PTS; i++) begin
          acc_r[i] <= sum_s[i];
        end
      end
      if (beat_s && last_s) begin
        out_valid_r <= 1'b1;
        out_col_r   <= col_r;
        col_r       <= col_r + KW'(1);
        out_sat_r   <= sat_s;
        for (int i = 0; i < PTS; i++) begin
          out_y_r[i*OW +: OW] <= y_s[i];
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_mac_array.sv
// Self-checking bench for dct_mac_array: table-driven columns with a scoreboard, plus hand-written
// backpressure, streaming, mid-column reset and saturation (FRAC=0 instance) sequences.
module tb_dct_mac_array;
  localparam int PTS = 8;
  localparam int XW  = 12;
  localparam int CW  = 8;
  localparam int OW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, in_valid, in_ready, out_valid, out_ready;
  logic [XW-1:0]     in_x;
  logic [PTS*CW-1:0] in_coef;
  logic [PTS*OW-1:0] out_y;
  logic [PTS-1:0]    out_sat;
  logic [2:0]        out_col;

  logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [XW-1:0]     s_in_x;
  logic [PTS*CW-1:0] s_in_coef;
  logic [PTS*OW-1:0] s_out_y;
  logic [PTS-1:0]    s_out_sat;
  logic [2:0]        s_out_col;

  dct_mac_array #(.PTS(PTS), .XW(XW), .CW(CW), .FRAC(7), .OW(OW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_sat(out_sat), .out_col(out_col));

  dct_mac_array #(.PTS(PTS), .XW(XW), .CW(CW), .FRAC(0), .OW(OW)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_x(s_in_x),
    .in_coef(s_in_coef), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_y(s_out_y),
    .out_sat(s_out_sat), .out_col(s_out_col));

  typedef struct {
    int         x[PTS];
    int         cval;
    bit         ident;
    int         ey[PTS];
    logic [7:0] esat;
  } vec_t;

  typedef struct {
    int         y[PTS];
    logic [7:0] sat;
    int         col;
  } exp_t;

  vec_t tbl[6];
  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   failed = 0;
  int   col_model = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PTS*CW-1:0] coef_vec(input bit ident, input int cval, input int k);
    logic [PTS*CW-1:0] v;
    for (int i = 0; i < PTS; i++) begin
      v[i*CW +: CW] = (ident && i != k) ? 8'sd0 : CW'(cval);
    end
    return v;
  endfunction

  task automatic push_exp(input int idx);
    exp_t e;
    for (int i = 0; i < PTS; i++) e.y[i] = tbl[idx].ey[i];
    e.sat = tbl[idx].esat;
    e.col = col_model;
    col_model = (col_model + 1) % PTS;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic beat(input int x, input logic [PTS*CW-1:0] c, output int waits);
    in_valid = 1'b1;
    in_x     = XW'(x);
    in_coef  = c;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_beats(input int idx, input int k0, input int k1, input int gap);
    int w;
    for (int k = k0; k <= k1; k++) begin
      beat(tbl[idx].x[k], coef_vec(tbl[idx].ident, tbl[idx].cval, k), w);
      chk("no_stall", w, 0);
      if (k == PTS-1) push_exp(idx);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic sat_col(input int x, input int cval, input int ey, input logic [7:0] esat, input int ecol);
    for (int k = 0; k < PTS; k++) begin
      s_in_valid = 1'b1;
      s_in_x     = XW'(x);
      s_in_coef  = coef_vec(1'b0, cval, k);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("sat_valid", s_out_valid, 1);
    chk("sat_in_ready", s_in_ready, 1);
    for (int i = 0; i < PTS; i++) chk($sformatf("sat_y%0d", i), $signed(s_out_y[i*OW +: OW]), ey);
    chk("sat_flags", s_out_sat, esat);
    chk("sat_col", s_out_col, ecol);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every delivered result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        for (int i = 0; i < PTS; i++) chk($sformatf("y%0d", i), $signed(out_y[i*OW +: OW]), mon_e.y[i]);
        chk("sat", out_sat, mon_e.sat);
        chk("col", out_col, mon_e.col);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tbl[0].x = '{-1, -2, -3, -4, -5, -6, -7, -8};
    tbl[0].cval = -128; tbl[0].ident = 1'b1;
    tbl[0].ey = '{1, 2, 3, 4, 5, 6, 7, 8}; tbl[0].esat = 8'h00;
    tbl[1].x = '{-3, -3, -3, -3, -3, -3, -3, -3};
    tbl[1].cval = 1; tbl[1].ident = 1'b0;
`ifdef DCT_MAC_ROUND_EN
    tbl[1].ey = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    tbl[1].ey = '{-1, -1, -1, -1, -1, -1, -1, -1};
`endif
    tbl[1].esat = 8'h00;
    tbl[2].x = '{5, -100, 2047, -2047, 0, -7, 1, -3};
    tbl[2].cval = -128; tbl[2].ident = 1'b1;
    tbl[2].ey = '{-5, 100, -2047, 2047, 0, 7, -1, 3}; tbl[2].esat = 8'h00;
    tbl[3].x = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    tbl[3].cval = 127; tbl[3].ident = 1'b0;
    tbl[3].ey = '{16248, 16248, 16248, 16248, 16248, 16248, 16248, 16248}; tbl[3].esat = 8'h00;
    tbl[4].x = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    tbl[4].cval = -128; tbl[4].ident = 1'b0;
    tbl[4].ey = '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384}; tbl[4].esat = 8'h00;
    tbl[5].x = '{1000, -200, 300, -400, 500, -600, 700, -800};
    tbl[5].cval = 100; tbl[5].ident = 1'b0;
`ifdef DCT_MAC_ROUND_EN
    tbl[5].ey = '{391, 391, 391, 391, 391, 391, 391, 391};
`else
    tbl[5].ey = '{390, 390, 390, 390, 390, 390, 390, 390};
`endif
    tbl[5].esat = 8'h00;

    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_coef = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_x = '0; s_in_coef = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_y", out_y, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_col", out_col, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table-driven columns, result drained before the next one.
    for (int t = 0; t < 6; t++) begin
      drive_beats(t, 0, PTS-1, t % 2);
      if (t == 0) begin
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
      end
      wait_drain();
    end

    // Backpressure: second column's final beat must stall while the first result is held.
    out_ready = 1'b0;
    drive_beats(0, 0, PTS-1, 0);
    drive_beats(2, 0, PTS-2, 0);
    in_valid = 1'b1;
    in_x     = XW'(tbl[2].x[PTS-1]);
    in_coef  = coef_vec(1'b1, -128, PTS-1);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_col", out_col, 6);
      for (int i = 0; i < PTS; i++) chk("bp_hold_y", $signed(out_y[i*OW +: OW]), tbl[0].ey[i]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    beat(tbl[2].x[PTS-1], coef_vec(1'b1, -128, PTS-1), w);
    chk("bp_release", w, 0);
    push_exp(2);
    @(negedge clk);
    chk("bp_no_bubble", out_valid, 1);
    wait_drain();

    // Streaming: nine back-to-back columns, out_col 0..7 then 0.
    for (int c = 0; c < 9; c++) drive_beats(c % 6, 0, PTS-1, 0);
    wait_drain();

    // Reset after five beats of a column; the partial column must vanish.
    drive_beats(2, 0, 4, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_y", out_y, 0);
    chk("mrst_col", out_col, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    col_model = 0;
    drive_beats(0, 0, PTS-1, 0);
    wait_drain();

    // FRAC=0 instance: clipping at both rails, and an unclipped column.
    sat_col(2047, 127, 32767, 8'hFF, 0);
    sat_col(-2048, 127, -32768, 8'hFF, 1);
    sat_col(100, 1, 800, 8'h00, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
